// File: rtl/clock_control.sv
// Clock control for a single-clock CPU trainer.
// Produces the debounce sample strobe, and the CPU clock-enable pulse in
// single-step, free-running (eight selectable rates) or halted operation.
//
// Operating state is visible on o_running / o_halted:
//   STEP    -> o_running=0, o_halted=0
//   RUN     -> o_running=1, o_halted=0
//   HALTED  -> o_running=0, o_halted=1
//
// Event priority inside one cycle: reset > halt > mode > step / run expiry.
// Rate buttons are independent of the state machine and act in every state.
module clock_control #(
    parameter int SAMPLE_DIV = 100000,
    parameter int BASE_DIV   = 40000,
    parameter int CNT_WIDTH  = 24
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    output logic       o_sample,
    input  logic       i_step,
    input  logic       i_mode,
    input  logic       i_faster,
    input  logic       i_slower,
    input  logic       i_halt,
    output logic       o_cpu_en,
    output logic       o_running,
    output logic       o_halted,
    output logic [2:0] o_rate
);

    typedef enum logic [1:0] {
        ST_STEP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'(SAMPLE_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] BASE_VAL    = CNT_WIDTH'(BASE_DIV);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [2:0]           RATE_RESET  = 3'd4;
    localparam logic [2:0]           RATE_MAX    = 3'd7;
    localparam logic [2:0]           RATE_MIN    = 3'd0;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_sample_cnt;
    logic [CNT_WIDTH-1:0] r_run_cnt;
    logic                 r_sample;
    logic                 r_cpu_en;
    logic                 r_running;
    logic                 r_halted;
    logic [2:0]           r_rate;

    logic [CNT_WIDTH-1:0] w_period;
    logic [CNT_WIDTH-1:0] w_period_last;
    logic                 w_rate_up;
    logic                 w_rate_dn;
    logic                 w_rate_change;
    logic                 w_run_expire;

    // Run period doubles for every step below the fastest rate (7).
    assign w_period      = BASE_VAL << (RATE_MAX - r_rate);
    assign w_period_last = w_period - CNT_ONE;
    assign w_run_expire  = (r_run_cnt == w_period_last);

    // Simultaneous faster+slower cancel; saturated requests are no-ops so
    // they must not disturb the run counter either.
    assign w_rate_up     = i_faster & ~i_slower & (r_rate != RATE_MAX);
    assign w_rate_dn     = i_slower & ~i_faster & (r_rate != RATE_MIN);
    assign w_rate_change = w_rate_up | w_rate_dn;

    // Free-running sample divider; strobe follows the terminal count by one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sample_cnt <= '0;
            r_sample     <= 1'b0;
        end else begin
            r_sample <= (r_sample_cnt == SAMPLE_LAST);
            if (r_sample_cnt == SAMPLE_LAST) begin
                r_sample_cnt <= '0;
            end else begin
                r_sample_cnt <= r_sample_cnt + CNT_ONE;
            end
        end
    end

    // State machine, run counter, rate register and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= ST_STEP;
            r_run_cnt <= '0;
            r_rate    <= RATE_RESET;
            r_cpu_en  <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_cpu_en <= 1'b0;

            if (w_rate_up) begin
                r_rate <= r_rate + 3'd1;
            end else if (w_rate_dn) begin
                r_rate <= r_rate - 3'd1;
            end

            if (i_halt) begin
                // Halt beats mode, step and a run expiry in the same cycle.
                r_state   <= ST_HALTED;
                r_run_cnt <= '0;
                r_running <= 1'b0;
                r_halted  <= 1'b1;
            end else begin
                case (r_state)
                    ST_STEP: begin
                        r_run_cnt <= '0;
                        r_halted  <= 1'b0;
                        if (i_mode) begin
                            // Mode wins over a coincident step: no pulse.
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_running <= 1'b0;
                            r_cpu_en  <= i_step;
                        end
                    end
                    ST_RUN: begin
                        r_halted <= 1'b0;
                        if (i_mode) begin
                            // Leaving RUN drops any pulse due this cycle.
                            r_state   <= ST_STEP;
                            r_running <= 1'b0;
                            r_run_cnt <= '0;
                        end else begin
                            r_running <= 1'b1;
                            r_cpu_en  <= w_run_expire;
                            if (w_run_expire || w_rate_change) begin
                                r_run_cnt <= '0;
                            end else begin
                                r_run_cnt <= r_run_cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_HALTED: begin
                        // Only reset leaves HALTED; step and mode are ignored.
                        r_run_cnt <= '0;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end
                    default: begin
                        r_state   <= ST_STEP;
                        r_run_cnt <= '0;
                        r_running <= 1'b0;
                        r_halted  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sample  = r_sample;
    assign o_cpu_en  = r_cpu_en;
    assign o_running = r_running;
    assign o_halted  = r_halted;
    assign o_rate    = r_rate;

endmodule

// File: tb/tb_clock_control.sv
// Directed bench for clock_control with SAMPLE_DIV=4, BASE_DIV=2.
// Inputs change 1 ns after a rising edge; outputs are read at the same point,
// so each check sees the result of the edge just taken.
module tb_clock_control;

    logic       clk;
    logic       reset_n;
    logic       sample;
    logic       step;
    logic       mode;
    logic       faster;
    logic       slower;
    logic       halt;
    logic       cpu_en;
    logic       running;
    logic       halted;
    logic [2:0] rate;

    int n_vec;
    int n_err;

    clock_control #(
        .SAMPLE_DIV(4),
        .BASE_DIV  (2),
        .CNT_WIDTH (24)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .o_sample (sample),
        .i_step   (step),
        .i_mode   (mode),
        .i_faster (faster),
        .i_slower (slower),
        .i_halt   (halt),
        .o_cpu_en (cpu_en),
        .o_running(running),
        .o_halted (halted),
        .o_rate   (rate)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        step   = 1'b0;
        mode   = 1'b0;
        faster = 1'b0;
        slower = 1'b0;
        halt   = 1'b0;
    endtask

    // One-cycle pulse on a chosen combination of buttons.
    task automatic pulse(input logic p_step, input logic p_mode,
                         input logic p_faster, input logic p_slower,
                         input logic p_halt);
        step   = p_step;
        mode   = p_mode;
        faster = p_faster;
        slower = p_slower;
        halt   = p_halt;
        tick();
        clear_inputs();
    endtask

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero_rate4(input string tag);
        check({tag, " sample"},  {31'd0, sample},  32'd0);
        check({tag, " cpu_en"},  {31'd0, cpu_en},  32'd0);
        check({tag, " running"}, {31'd0, running}, 32'd0);
        check({tag, " halted"},  {31'd0, halted},  32'd0);
        check({tag, " rate"},    {29'd0, rate},    32'd4);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        clear_inputs();

        // Reset state
        repeat (3) tick();
        check_all_zero_rate4("reset");

        // Idle after release: sample every 4th cycle, no cpu_en
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("idle sample", {31'd0, sample}, (k % 4 == 0) ? 32'd1 : 32'd0);
            check("idle cpu_en", {31'd0, cpu_en}, 32'd0);
        end

        // Single step: pulse one cycle after the press, then gone
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("step en", {31'd0, cpu_en}, 32'd1);
        tick();
        check("step en gone", {31'd0, cpu_en}, 32'd0);
        check("step still step", {31'd0, running}, 32'd0);

        // Step+mode together: enters RUN, no pulse
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mode running", {31'd0, running}, 32'd1);
        check("mode no en", {31'd0, cpu_en}, 32'd0);

        // RUN at rate 4: period 2<<3 = 16
        for (int i = 1; i <= 32; i++) begin
            tick();
            check("run r4 en", {31'd0, cpu_en}, (i == 16 || i == 32) ? 32'd1 : 32'd0);
        end

        // Three faster presses -> rate 7, period 2
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("faster x3 rate", {29'd0, rate}, 32'd7);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("run r7 en", {31'd0, cpu_en}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Fourth faster saturates and must not restart the period
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("faster sat rate", {29'd0, rate}, 32'd7);
        check("faster sat en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("faster sat keeps period", {31'd0, cpu_en}, 32'd1);

        // Back to rate 4, then eight slower presses -> rate 0
        repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("slower to 4", {29'd0, rate}, 32'd4);
        repeat (8) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("slower sat rate", {29'd0, rate}, 32'd0);
        // Last four presses were saturated: counter ran on to 4, period 256
        for (int j = 1; j <= 508; j++) begin
            tick();
            check("run r0 en", {31'd0, cpu_en}, (j == 252 || j == 508) ? 32'd1 : 32'd0);
        end

        // Faster and slower together: no change
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("both rate", {29'd0, rate}, 32'd0);

        // Up to rate 7, halt exactly on the expiry cycle
        repeat (7) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("up to 7", {29'd0, rate}, 32'd7);
        tick();
        check("pre-halt en", {31'd0, cpu_en}, 32'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("halt en", {31'd0, cpu_en}, 32'd0);
        check("halt halted", {31'd0, halted}, 32'd1);
        check("halt running", {31'd0, running}, 32'd0);

        // Halted ignores step and mode, rate still moves
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halted step en", {31'd0, cpu_en}, 32'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halted mode running", {31'd0, running}, 32'd0);
        check("halted mode halted", {31'd0, halted}, 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("halted rate", {29'd0, rate}, 32'd6);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("halted idle en", {31'd0, cpu_en}, 32'd0);
        end

        // Reset mid-HALTED
        reset_n = 1'b0;
        tick();
        check_all_zero_rate4("reset halted");
        reset_n = 1'b1;

        // Reset mid-RUN on the expiry edge, with halt also asserted
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rerun running", {31'd0, running}, 32'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rerun rate", {29'd0, rate}, 32'd5);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rerun r5 en", {31'd0, cpu_en}, 32'd0);
        end
        reset_n = 1'b0;
        halt    = 1'b1;
        tick();
        check_all_zero_rate4("reset run");
        halt    = 1'b0;
        reset_n = 1'b1;

        // Back in STEP after reset
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post reset step en", {31'd0, cpu_en}, 32'd1);
        check("post reset halted", {31'd0, halted}, 32'd0);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_control.md
CLOCK_CONTROL -- requirements
Module: clock_control

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 100000, giving the cycles between o_sample strobes (must be >= 2).
REQ-002 The block SHALL have parameter BASE_DIV, default 40000, giving the cycles per CPU tick at the fastest rate (must be >= 1).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 24, giving the width of all internal counters (must hold BASE_DIV<<7 and SAMPLE_DIV).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port o_sample, output, 1 bit: a one-cycle debounce sample strobe that drives the i_sample input of every button stage.
REQ-007 The block SHALL have ports i_step, i_mode, i_faster and i_slower, inputs, 1 bit each: one-cycle pulses from the debounced button stages.
REQ-008 The block SHALL have port i_halt, input, 1 bit: the CPU HLT level.
REQ-009 The block SHALL have port o_cpu_en, output, 1 bit: the one-cycle CPU clock-enable pulse.
REQ-010 The block SHALL have port o_running, output, 1 bit: high in RUN state.
REQ-011 The block SHALL have port o_halted, output, 1 bit: high in HALTED state.
REQ-012 The block SHALL have port o_rate, output, 3 bits: the current rate index, where 7 is fastest.

Function
REQ-013 The sample counter SHALL count 0..SAMPLE_DIV-1 and wrap to 0; o_sample is high exactly in the cycle after the counter equals SAMPLE_DIV-1, which gives one pulse every SAMPLE_DIV cycles in all states.
REQ-014 The state machine SHALL have the states STEP, RUN and HALTED, and all outputs SHALL be registered.
REQ-015 In STEP, an i_step pulse SHALL produce o_cpu_en high for exactly one cycle, in the cycle after the pulse (1-cycle latency).
REQ-016 In STEP, i_mode SHALL move the state to RUN and clear the run counter; if i_step and i_mode are high together, the mode change occurs and no o_cpu_en pulse is produced.
REQ-017 In RUN, the run period SHALL be BASE_DIV << (7 - o_rate) cycles; the run counter increments each cycle, and on reaching period-1 it clears and o_cpu_en pulses in the next cycle.
REQ-018 In RUN, i_step SHALL be ignored, and i_mode SHALL return the state to STEP, clear the run counter and suppress any pulse scheduled for that cycle.
REQ-019 i_faster SHALL increment o_rate, saturating at 7.
REQ-020 i_slower SHALL decrement o_rate, saturating at 0.
REQ-021 If i_faster and i_slower are high in the same cycle, o_rate SHALL not change.
REQ-022 Any change of o_rate SHALL clear the run counter; a rate request at saturation causes no change and therefore no counter clear.
REQ-023 i_halt high in any cycle SHALL force the next state to HALTED, and halt SHALL take priority over mode, step and run-expiry events in the same cycle, with no o_cpu_en pulse.
REQ-024 In HALTED, o_cpu_en SHALL be 0, o_halted SHALL be 1 and o_running SHALL be 0; i_step and i_mode are ignored, rate buttons still update o_rate, and the state is left only by reset.
REQ-025 o_cpu_en SHALL never be high for two consecutive cycles, except in RUN with period 1 (BASE_DIV=1 at rate 7).

Reset
REQ-026 While i_reset_n=0 at a rising edge, the next state SHALL be STEP, o_rate SHALL be 4, and the sample and run counters SHALL be 0.
REQ-027 While i_reset_n=0 at a rising edge, o_sample, o_cpu_en, o_running and o_halted SHALL all be 0.
REQ-028 Reset SHALL override every input, including i_halt and a pulse pending from the previous cycle.
REQ-029 Reset asserted mid-run SHALL cancel any in-progress period, and no o_cpu_en pulse SHALL appear in the cycle after reset is asserted.

Verification (SAMPLE_DIV=4, BASE_DIV=2)
REQ-030 Release reset and idle 20 cycles -> o_sample pulses at cycles 4, 8, 12, 16, 20, and o_cpu_en stays 0.
REQ-031 In STEP, pulse i_step at cycle N -> o_cpu_en is 1 at N+1 only; pulse i_step and i_mode together -> o_running=1 and no o_cpu_en.
REQ-032 Enter RUN at rate 4 -> o_cpu_en pulses every 16 cycles; pulse i_faster three times -> o_rate=7 and the period is 2; a fourth i_faster -> o_rate stays 7.
REQ-033 Pulse i_slower eight times from rate 4 -> o_rate=0 and the period is 256; i_faster and i_slower together -> o_rate unchanged.
REQ-034 In RUN, raise i_halt in the cycle the run counter expires -> no o_cpu_en pulse, o_halted=1 and o_running=0; subsequent i_step or i_mode -> no effect.
REQ-035 Assert reset mid-RUN and mid-HALTED -> STEP state, o_rate=4, and all outputs 0 in the next cycle.
